// File: rtl/timer_xn.sv
// -----------------------------------------------------------------------------
// timer_xn - memory-mapped multi-channel down-counter / timer peripheral.
//
// Each channel owns four word registers selected by addr[1:0]:
//   0 CTRL  : [0] EN, [2:1] MODE, [3] IE, [8+PW-1:8] P (prescale), [31] DONE
//             (DONE is sticky; writing 1 to bit 31 clears it)
//   1 LOAD  : reload value
//   2 CMP   : PWM compare value
//   3 COUNT : current count (read-only)
// addr[AW-1:2] selects the channel; channel indices >= CH read 0 and ignore
// writes.
//
// Ports:
//   clk     system clock, rising-edge active
//   RSTN    asynchronous active-low reset
//   we      register write strobe
//   addr    word address
//   wdata   write data (bits above W ignored for LOAD/CMP)
//   rdata   read data, combinational from addr and register state
//   ch_out  per-channel output, registered
//   irq     registered OR over channels of (DONE & IE)
// -----------------------------------------------------------------------------
module timer_xn #(
    parameter int CH = 3,
    parameter int W  = 32,
    parameter int PW = 8,
    parameter int AW = $clog2(CH) + 2
) (
    input  logic          clk,
    input  logic          RSTN,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [CH-1:0] ch_out,
    output logic          irq
);

    // Channel-select width; a single-channel build has no select bits, so a
    // one-bit select tied to zero stands in.
    localparam int CW = (AW > 2) ? AW - 2 : 1;

    localparam logic [1:0] MODE_PER = 2'b01;
    localparam logic [1:0] MODE_PWM = 2'b10;

    logic [CW-1:0] sel;
    logic          sel_valid;
    logic [1:0]    reg_sel;
    logic [31:0]   ch_rdata [CH];
    logic [CH-1:0] irq_src;
    logic          unused_wdata;

    generate
        if (AW > 2) begin : g_sel
            assign sel = addr[AW-1:2];
        end else begin : g_sel_single
            assign sel = '0;
        end
    endgenerate

    assign reg_sel      = addr[1:0];
    assign sel_valid    = ({1'b0, sel} < (CW + 1)'(CH));
    assign unused_wdata = ^wdata;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic          en_reg, en_next;
            logic [1:0]    mode_reg, mode_next;
            logic          ie_reg, ie_next;
            logic [PW-1:0] p_reg, p_next;
            logic          done_reg, done_next;
            logic [W-1:0]  load_reg, load_next;
            logic [W-1:0]  cmp_reg, cmp_next;
            logic [W-1:0]  count_reg, count_next;
            logic [PW-1:0] presc_reg, presc_next;
            logic          out_reg, out_next;
            logic          hit, wr_ctrl, wr_load, wr_cmp;
            logic          arm, stop, tick;
            logic [31:0]   ctrl_word, rd_word;

            assign hit     = we && sel_valid && (sel == CW'(gi));
            assign wr_ctrl = hit && (reg_sel == 2'd0);
            assign wr_load = hit && (reg_sel == 2'd1);
            assign wr_cmp  = hit && (reg_sel == 2'd2);

            always_comb begin
                en_next    = en_reg;
                mode_next  = mode_reg;
                ie_next    = ie_reg;
                p_next     = p_reg;
                done_next  = done_reg;
                load_next  = load_reg;
                cmp_next   = cmp_reg;
                count_next = count_reg;
                presc_next = presc_reg;
                out_next   = out_reg;

                arm  = wr_ctrl && wdata[0] && !en_reg;
                stop = wr_ctrl && !wdata[0];
                // A stopping CTRL write swallows a coincident tick; arming
                // can only happen with EN=0, so it never ticks in that cycle.
                tick = en_reg && !stop && (presc_reg == p_reg);

                if (wr_ctrl) begin
                    en_next   = wdata[0];
                    mode_next = wdata[2:1];
                    ie_next   = wdata[3];
                    p_next    = wdata[8+PW-1:8];
                    if (wdata[31]) begin
                        done_next = 1'b0;
                    end
                end
                if (wr_load) begin
                    load_next = wdata[W-1:0];
                end
                if (wr_cmp) begin
                    cmp_next = wdata[W-1:0];
                end

                if (arm) begin
                    count_next = load_reg;
                    presc_next = '0;
                    out_next   = 1'b0;
                end else if (en_reg && !stop) begin
                    presc_next = tick ? '0 : presc_reg + PW'(1);
                end

                // Terminal check comes first, so the decrement never wraps.
                // A hardware DONE set here overrides a same-cycle clear.
                if (tick) begin
                    if (count_reg != '0) begin
                        count_next = count_reg - W'(1);
                    end else begin
                        done_next = 1'b1;
                        case (mode_reg)
                            MODE_PER: begin
                                count_next = load_reg;
                                out_next   = ~out_reg;
                            end
                            MODE_PWM: begin
                                count_next = load_reg;
                            end
                            default: begin
                                en_next  = 1'b0;
                                out_next = 1'b1;
                            end
                        endcase
                    end
                end

                // PWM output tracks the upcoming count against the live CMP,
                // so a CMP write shows on the very next cycle.
                if (en_next && (mode_next == MODE_PWM)) begin
                    out_next = (count_next < cmp_next);
                end
            end

            always_ff @(posedge clk or negedge RSTN) begin
                if (!RSTN) begin
                    en_reg    <= 1'b0;
                    mode_reg  <= '0;
                    ie_reg    <= 1'b0;
                    p_reg     <= '0;
                    done_reg  <= 1'b0;
                    load_reg  <= '0;
                    cmp_reg   <= '0;
                    count_reg <= '0;
                    presc_reg <= '0;
                    out_reg   <= 1'b0;
                end else begin
                    en_reg    <= en_next;
                    mode_reg  <= mode_next;
                    ie_reg    <= ie_next;
                    p_reg     <= p_next;
                    done_reg  <= done_next;
                    load_reg  <= load_next;
                    cmp_reg   <= cmp_next;
                    count_reg <= count_next;
                    presc_reg <= presc_next;
                    out_reg   <= out_next;
                end
            end

            always_comb begin
                ctrl_word             = '0;
                ctrl_word[0]          = en_reg;
                ctrl_word[2:1]        = mode_reg;
                ctrl_word[3]          = ie_reg;
                ctrl_word[8+PW-1:8]   = p_reg;
                ctrl_word[31]         = done_reg;
            end

            always_comb begin
                case (reg_sel)
                    2'd0:    rd_word = ctrl_word;
                    2'd1:    rd_word = 32'(load_reg);
                    2'd2:    rd_word = 32'(cmp_reg);
                    default: rd_word = 32'(count_reg);
                endcase
            end

            assign ch_out[gi]   = out_reg;
            assign irq_src[gi]  = done_reg & ie_reg;
            assign ch_rdata[gi] = rd_word;
        end
    endgenerate

    always_comb begin
        rdata = '0;
        for (int i = 0; i < CH; i++) begin
            if (sel_valid && (sel == CW'(i))) begin
                rdata = ch_rdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            irq <= 1'b0;
        end else begin
            irq <= |irq_src;
        end
    end

endmodule

// File: tb/tb_timer_xn.sv
// -----------------------------------------------------------------------------
// tb_timer_xn - directed self-checking bench for timer_xn (CH=3, W=32, PW=8).
// Inputs change on the falling clock edge; outputs are sampled there too.
// A register write issued by wr() lands on the second rising edge after the
// call, and wr() returns at the falling edge that follows that rising edge.
// -----------------------------------------------------------------------------
module tb_timer_xn;
    localparam int CH = 3;
    localparam int W  = 32;
    localparam int PW = 8;
    localparam int AW = 4;

    logic          clk  = 1'b0;
    logic          RSTN = 1'b1;
    logic          we   = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic [CH-1:0] ch_out;
    logic          irq;

    int errors = 0;
    int checks = 0;

    timer_xn #(.CH(CH), .W(W), .PW(PW), .AW(AW)) dut (
        .clk    (clk),
        .RSTN   (RSTN),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ch_out (ch_out),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        we = 1'b0;
        $display("wr addr=%0d data=%08h", a, d);
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1 RSTN = 1'b0;
        #1;
        checks++; if (ch_out !== 3'b000) begin errors++; $display("FAIL por_ch_out got=%b exp=000", ch_out); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL por_irq got=%b exp=0", irq); end
        @(negedge clk);
        RSTN = 1'b1;
        // ch0 periodic, LOAD=1, IE: terminal every 2 cycles from edge 2
        wr(4'd1, 32'd1);
        wr(4'd0, 32'h0000_000B);
        cyc(7);
        checks++; if (ch_out !== 3'b001) begin errors++; $display("FAIL pre_rst_ch_out got=%b exp=001", ch_out); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_rst_irq got=%b exp=1", irq); end
        #2 RSTN = 1'b0;
        #1;
        checks++; if (ch_out !== 3'b000) begin errors++; $display("FAIL rst_ch_out got=%b exp=000", ch_out); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
        for (int a = 0; a < 16; a++) begin
            rd(AW'(a), d);
            checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_rdata addr=%0d got=%08h exp=0", a, d); end
        end
        @(negedge clk);
        RSTN = 1'b1;
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        wr(4'd1, 32'd4);
        wr(4'd0, 32'h0000_0009);
        rd(4'd3, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL os_arm_count got=%0d exp=4", d); end
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            rd(4'd0, d);
            if (k == 4) begin
                checks++; if (d[31] !== 1'b0) begin errors++; $display("FAIL os_done_early got=%b exp=0", d[31]); end
                checks++; if (ch_out[0] !== 1'b0) begin errors++; $display("FAIL os_out_early got=%b exp=0", ch_out[0]); end
            end
            if (k == 5) begin
                checks++; if (d[31] !== 1'b1) begin errors++; $display("FAIL os_done got=%b exp=1", d[31]); end
                checks++; if (ch_out[0] !== 1'b1) begin errors++; $display("FAIL os_out got=%b exp=1", ch_out[0]); end
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_irq_early got=%b exp=0", irq); end
            end
            if (k == 6) begin
                checks++; if (irq !== 1'b1) begin errors++; $display("FAIL os_irq got=%b exp=1", irq); end
                checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL os_en_cleared got=%b exp=0", d[0]); end
                rd(4'd3, d);
                checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_count got=%0d exp=0", d); end
            end
        end
        wr(4'd0, 32'h8000_0000);
        rd(4'd0, d);
        checks++; if (d[31] !== 1'b0) begin errors++; $display("FAIL os_w1c got=%b exp=0", d[31]); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL os_irq_hold got=%b exp=1", irq); end
        cyc(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_irq_drop got=%b exp=0", irq); end
        checks++; if (ch_out[0] !== 1'b1) begin errors++; $display("FAIL os_out_hold got=%b exp=1", ch_out[0]); end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        // ch1 LOAD=2, P=3, periodic: terminal every 12 cycles (edges 12, 24, 36)
        wr(4'd5, 32'd2);
        wr(4'd4, 32'h0000_0303);
        cyc(11);
        checks++; if (ch_out[1] !== 1'b0) begin errors++; $display("FAIL per_e11 got=%b exp=0", ch_out[1]); end
        cyc(1);
        checks++; if (ch_out[1] !== 1'b1) begin errors++; $display("FAIL per_e12 got=%b exp=1", ch_out[1]); end
        rd(4'd4, d);
        checks++; if (d[31] !== 1'b1) begin errors++; $display("FAIL per_done got=%b exp=1", d[31]); end
        cyc(11);
        checks++; if (ch_out[1] !== 1'b1) begin errors++; $display("FAIL per_e23 got=%b exp=1", ch_out[1]); end
        cyc(1);
        checks++; if (ch_out[1] !== 1'b0) begin errors++; $display("FAIL per_e24 got=%b exp=0", ch_out[1]); end
        cyc(10);
        wr(4'd4, 32'h8000_0303);   // W1C lands on terminal edge 36
        rd(4'd4, d);
        checks++; if (d[31] !== 1'b1) begin errors++; $display("FAIL per_set_wins got=%b exp=1", d[31]); end
        checks++; if (ch_out[1] !== 1'b1) begin errors++; $display("FAIL per_e36 got=%b exp=1", ch_out[1]); end
        wr(4'd4, 32'h8000_0303);   // edge 38, no tick
        rd(4'd4, d);
        checks++; if (d[31] !== 1'b0) begin errors++; $display("FAIL per_w1c got=%b exp=0", d[31]); end
        wr(4'd4, 32'h0000_0000);
    endtask

    task automatic test_pwm();
        // ch2 LOAD=9, CMP=3: high after edges where k mod 10 is 7, 8 or 9
        wr(4'd9, 32'd9);
        wr(4'd10, 32'd3);
        wr(4'd8, 32'h0000_0005);
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            checks++;
            if (ch_out[2] !== ((k % 10) >= 7)) begin
                errors++; $display("FAIL pwm_cycle k=%0d got=%b exp=%b", k, ch_out[2], ((k % 10) >= 7));
            end
        end
        cyc(5);
        wr(4'd10, 32'd0);          // edge 27, where output would otherwise be high
        for (int j = 0; j < 12; j++) begin
            checks++; if (ch_out[2] !== 1'b0) begin errors++; $display("FAIL pwm_cmp0 j=%0d got=%b exp=0", j, ch_out[2]); end
            cyc(1);
        end
        wr(4'd8, 32'h0000_0000);
    endtask

    task automatic test_load_update();
        logic [31:0] d;
        logic        e;
        wr(4'd1, 32'd5);
        wr(4'd0, 32'h0000_0003);
        wr(4'd1, 32'd1);           // edge 2
        rd(4'd3, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL ld_no_reload got=%0d exp=3", d); end
        for (int k = 3; k <= 11; k++) begin
            cyc(1);
            e = ((k >= 6) && (k <= 7)) || (k >= 10);
            checks++; if (ch_out[0] !== e) begin errors++; $display("FAIL ld_period k=%0d got=%b exp=%b", k, ch_out[0], e); end
        end
        wr(4'd0, 32'h0000_0000);   // edge 13: stop drops that tick
        rd(4'd3, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL ld_frozen_count got=%0d exp=1", d); end
        checks++; if (ch_out[0] !== 1'b0) begin errors++; $display("FAIL ld_out_hold got=%b exp=0", ch_out[0]); end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        for (int a = 12; a < 16; a++) begin
            wr(AW'(a), 32'hFFFF_FFFF);
        end
        for (int a = 12; a < 16; a++) begin
            rd(AW'(a), d);
            checks++; if (d !== 32'd0) begin errors++; $display("FAIL dec_ch3 addr=%0d got=%08h exp=0", a, d); end
        end
        rd(4'd1, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL dec_ch0_load got=%0d exp=1", d); end
        rd(4'd5, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL dec_ch1_load got=%0d exp=2", d); end
        rd(4'd9, d);
        checks++; if (d !== 32'd9) begin errors++; $display("FAIL dec_ch2_load got=%0d exp=9", d); end
        rd(4'd10, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL dec_ch2_cmp got=%0d exp=0", d); end
        checks++; if (ch_out !== 3'b010) begin errors++; $display("FAIL dec_ch_out got=%b exp=010", ch_out); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL dec_irq got=%b exp=0", irq); end
        wr(4'd3, 32'd77);
        rd(4'd3, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL dec_count_ro got=%0d exp=1", d); end
    endtask

    task automatic test_load_zero();
        logic [31:0] d;
        wr(4'd5, 32'd0);
        wr(4'd4, 32'h0000_0003);
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            rd(4'd4, d);
            checks++; if (ch_out[1] !== k[0]) begin errors++; $display("FAIL lz_toggle k=%0d got=%b exp=%b", k, ch_out[1], k[0]); end
            checks++; if (d[31] !== 1'b1) begin errors++; $display("FAIL lz_done k=%0d got=%b exp=1", k, d[31]); end
        end
        wr(4'd4, 32'h0000_0000);
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pwm();
        test_load_update();
        test_decode();
        test_load_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
